mips_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS CPU datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states, arbitrates the single shared instruction/data memory port through a request/ready handshake, and drives every datapath strobe and mux select. It sits beside the datapath inside `mips`: it takes the opcode/funct fields from the instruction register and the ALU zero flag, and returns one-hot-in-time write enables plus select codes.

---
 rtl/mips_mc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the shared memory port handshake.
module mips_mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       instr_done;
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] pc_sel;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  ctrl_t       ctrl_c, ctrl_o;

  logic is_rtype, is_add, is_sub, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal;
  logic supported;

  assign is_rtype  = (op == 6'h00);
  assign is_add    = is_rtype && (funct == 6'h20);
  assign is_sub    = is_rtype && (funct == 6'h22);
  assign is_jr     = is_rtype && (funct == 6'h08);
  assign is_ori    = (op == 6'h0D);
  assign is_lw     = (op == 6'h23);
  assign is_sw     = (op == 6'h2B);
  assign is_beq    = (op == 6'h04);
  assign is_lui    = (op == 6'h0F);
  assign is_jal    = (op == 6'h03);
  assign supported = is_add | is_sub | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_jal;

  // Next-state and strobe decode from the current state and instruction fields
  always_comb begin
    ctrl_c  = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl_c.ir_we = 1'b1;
          ctrl_c.pc_we = 1'b1;
          state_d      = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_jal) begin
          ctrl_c.reg_we  = 1'b1;
          ctrl_c.reg_dst = 2'd2;
          ctrl_c.wd_sel  = 2'd2;
          ctrl_c.pc_we   = 1'b1;
          ctrl_c.pc_sel  = 2'd2;
          state_d        = S_FETCH;
        end else if (is_jr) begin
          ctrl_c.pc_we  = 1'b1;
          ctrl_c.pc_sel = 2'd3;
          state_d       = S_FETCH;
        end else if (!supported) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_add) begin
          state_d = S_WB;
        end else if (is_sub) begin
          ctrl_c.alu_op = 3'd1;
          state_d       = S_WB;
        end else if (is_ori) begin
          ctrl_c.alu_op    = 3'd2;
          ctrl_c.alu_src_b = 2'd1;
          state_d          = S_WB;
        end else if (is_lui) begin
          ctrl_c.alu_op    = 3'd3;
          ctrl_c.alu_src_b = 2'd1;
          state_d          = S_WB;
        end else if (is_lw || is_sw) begin
          ctrl_c.alu_src_b = 2'd2;
          state_d          = S_MEM;
        end else if (is_beq) begin
          ctrl_c.alu_op = 3'd1;
          ctrl_c.pc_we  = zero;
          ctrl_c.pc_sel = 2'd1;
          state_d       = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.mem_we  = is_sw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        ctrl_c.reg_we  = 1'b1;
        ctrl_c.reg_dst = (is_add || is_sub) ? 2'd1 : 2'd0;
        ctrl_c.wd_sel  = is_lw ? 2'd1 : 2'd0;
        state_d        = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // A FETCH stall is not a completion; every other return to FETCH is
    ctrl_c.instr_done = (state_d == S_FETCH) && (state_q != S_FETCH);
    retired_d         = retired_q + {31'd0, ctrl_c.instr_done};
  end

  // State and retirement counter, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign ctrl_o     = reset ? ctrl_c : '0;
  assign mem_req    = ctrl_o.mem_req;
  assign mem_we     = ctrl_o.mem_we;
  assign pc_we      = ctrl_o.pc_we;
  assign ir_we      = ctrl_o.ir_we;
  assign reg_we     = ctrl_o.reg_we;
  assign instr_done = ctrl_o.instr_done;
  assign alu_op     = ctrl_o.alu_op;
  assign alu_src_b  = ctrl_o.alu_src_b;
  assign reg_dst    = ctrl_o.reg_dst;
  assign wd_sel     = ctrl_o.wd_sel;
  assign pc_sel     = ctrl_o.pc_sel;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: per-instruction step tables predict every cycle's
// strobes; a directed prologue pins latencies, then random instructions follow.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, pc_we, ir_we, reg_we, instr_done;
  logic [2:0]  alu_op, state;
  logic [1:0]  alu_src_b, reg_dst, wd_sel, pc_sel;
  logic [31:0] retired;
  logic [19:0] act;

  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we),
    .ir_we(ir_we), .reg_we(reg_we), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .pc_sel(pc_sel), .state(state),
    .instr_done(instr_done), .retired(retired)
  );

  assign act = {mem_req, mem_we, pc_we, ir_we, reg_we, instr_done,
                alu_op, alu_src_b, reg_dst, wd_sel, pc_sel, state};

  localparam int C_ADD = 0, C_SUB = 1, C_JR = 2, C_ORI = 3, C_LW = 4;
  localparam int C_SW = 5, C_BEQ = 6, C_LUI = 7, C_JAL = 8, C_NOP = 9;
  localparam int NPROG = 300;
  localparam int NDIR  = 12;

  logic [5:0]  p_op[NPROG];
  logic [5:0]  p_funct[NPROG];
  logic        p_zero[NPROG];
  int          p_stall[NPROG];
  int          lat[NPROG];
  int          tr[$];
  int          idx = 0;
  int          mdl_pos = 0;
  int          mdl_step = 0;
  int          cyc_in = 0;
  logic [31:0] mdl_retired = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, a, e);
    end
  endtask

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: begin
        if (f == 6'h20) return C_ADD;
        if (f == 6'h22) return C_SUB;
        if (f == 6'h08) return C_JR;
        return C_NOP;
      end
      6'h0D:   return C_ORI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h0F:   return C_LUI;
      6'h03:   return C_JAL;
      default: return C_NOP;
    endcase
  endfunction

  // Number of steps (F,D,E,M,W) an instruction class walks through
  function automatic int seq_len(input int c);
    case (c)
      C_JAL, C_JR, C_NOP: return 2;
      C_BEQ:              return 3;
      C_LW:               return 5;
      default:            return 4;
    endcase
  endfunction

  // Step code at position p: 0 F, 1 D, 2 E, 3 M, 4 W
  function automatic int step_at(input int c, input int p);
    if (p == 3) return (c == C_LW || c == C_SW) ? 3 : 4;
    return p;
  endfunction

  function automatic logic [19:0] expect_out(input int c, input int st, input logic z,
                                             input logic mr, input logic dn);
    logic       mrq = 1'b0, mwe = 1'b0, pwe = 1'b0, iwe = 1'b0, rwe = 1'b0;
    logic [2:0] aop = 3'd0;
    logic [1:0] asb = 2'd0, rd = 2'd0, wds = 2'd0, psel = 2'd0;
    case (st)
      0: begin mrq = 1'b1; iwe = mr; pwe = mr; end
      1: begin
        if (c == C_JAL) begin rwe = 1'b1; rd = 2'd2; wds = 2'd2; pwe = 1'b1; psel = 2'd2; end
        else if (c == C_JR) begin pwe = 1'b1; psel = 2'd3; end
      end
      2: begin
        case (c)
          C_SUB:       aop = 3'd1;
          C_ORI:       begin aop = 3'd2; asb = 2'd1; end
          C_LUI:       begin aop = 3'd3; asb = 2'd1; end
          C_LW, C_SW:  asb = 2'd2;
          C_BEQ:       begin aop = 3'd1; pwe = z; psel = 2'd1; end
          default:     aop = 3'd0;
        endcase
      end
      3: begin mrq = 1'b1; mwe = (c == C_SW); end
      4: begin
        rwe = 1'b1;
        rd  = (c == C_ADD || c == C_SUB) ? 2'd1 : 2'd0;
        wds = (c == C_LW) ? 2'd1 : 2'd0;
      end
      default: mrq = 1'b0;
    endcase
    return {mrq, mwe, pwe, iwe, rwe, dn, aop, asb, rd, wds, psel, 3'(st)};
  endfunction

  // Compare process: check outputs against the model, then advance the model
  always @(negedge clk) begin
    int   c, st;
    logic adv, dn;
    if (reset !== 1'b1) begin
      check("reset_outputs", {12'd0, act}, 32'd0);
      check("reset_retired", retired, 32'd0);
      mdl_pos = 0; mdl_step = 0; cyc_in = 0; mdl_retired = 32'd0;
    end else begin
      c   = classify(op, funct);
      st  = step_at(c, mdl_pos);
      adv = !((st == 0 || st == 3) && !mem_ready);
      dn  = adv && (mdl_pos == seq_len(c) - 1);
      check("outputs", {12'd0, act}, {12'd0, expect_out(c, st, zero, mem_ready, dn)});
      check("retired", retired, mdl_retired);
      cyc_in++;
      if (idx == 1) tr.push_back(int'(state));
      if (adv) mdl_pos++;
      if (dn) begin
        if (idx < NPROG) lat[idx] = cyc_in;
        cyc_in = 0; mdl_pos = 0; mdl_retired++; idx++;
      end
      mdl_step = step_at(classify(op, funct), mdl_pos);
    end
  end

  initial begin
    int   stall_left, cyc, rst_hold, r;
    logic did_reset, pins_done;
    int   exp_lat[11] = '{4, 7, 3, 3, 2, 2, 2, 4, 4, 4, 4};
    int   exp_tr[7]   = '{0, 1, 2, 3, 3, 3, 4};

    for (int i = 0; i < NPROG; i++) begin
      p_op[i] = 6'h00; p_funct[i] = 6'h00; p_zero[i] = 1'b0; p_stall[i] = 0;
    end
    p_funct[0] = 6'h20;
    p_op[1] = 6'h23; p_stall[1] = 2;
    p_op[2] = 6'h04; p_zero[2] = 1'b1;
    p_op[3] = 6'h04; p_zero[3] = 1'b0;
    p_op[4] = 6'h03;
    p_funct[5] = 6'h08;
    p_op[6] = 6'h3F;
    p_funct[7] = 6'h22;
    p_op[8] = 6'h0D;
    p_op[9] = 6'h0F;
    p_op[10] = 6'h2B;
    p_op[11] = 6'h2B;
    for (int i = NDIR; i < NPROG; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: p_funct[i] = 6'h20;
        1: p_funct[i] = 6'h22;
        2: p_funct[i] = 6'h08;
        3: p_op[i] = 6'h0D;
        4: p_op[i] = 6'h23;
        5: p_op[i] = 6'h2B;
        6: p_op[i] = 6'h04;
        7: p_op[i] = 6'h0F;
        8: p_op[i] = 6'h03;
        9: p_funct[i] = 6'($urandom);
        10: begin p_op[i] = 6'($urandom); p_funct[i] = 6'($urandom); end
        default: p_op[i] = 6'h00;
      endcase
      p_zero[i] = 1'($urandom);
    end

    reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    stall_left = 0; cyc = 0; rst_hold = 0; did_reset = 1'b0; pins_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    while (idx < NPROG && cyc < 20000) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end
      if (mdl_pos == 0) begin
        op = p_op[idx]; funct = p_funct[idx]; zero = p_zero[idx];
        stall_left = p_stall[idx];
      end
      if (idx < NDIR) begin
        mem_ready = !(mdl_step == 3 && stall_left > 0);
        if (!mem_ready) stall_left--;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      if (idx >= 11 && !pins_done) begin
        pins_done = 1'b1;
        for (int k = 0; k < 11; k++) check($sformatf("latency_%0d", k), lat[k], exp_lat[k]);
        check("retired_after_directed", retired, 32'd11);
        check("lw_trace_len", tr.size(), 7);
        for (int k = 0; k < 7 && k < tr.size(); k++)
          check($sformatf("lw_trace_%0d", k), tr[k], exp_tr[k]);
      end
      if (idx == 11 && mdl_step == 3 && !did_reset && reset === 1'b1) begin
        did_reset = 1'b1;
        reset     = 1'b0;
        rst_hold  = 2;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: retired %0d of %0d instructions", idx, NPROG);
    end
    check("reset_test_ran", {31'd0, did_reset}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
